// File: rtl/dfd_trace_pkg.sv
// Shared widths and FSM encoding for the trace-buffer read-side extractor.
package dfd_trace_pkg;

  localparam int unsigned ACC_BYTES  = 64;
  localparam int unsigned BANK_BYTES = 32;

  // rd_ptr indexes a byte within one line; counts must also hold ACC_BYTES itself.
  localparam int unsigned PTR_W   = $clog2(ACC_BYTES);
  localparam int unsigned CNT_W   = PTR_W + 1;
  // Bytes available across both entries can reach 2*ACC_BYTES.
  localparam int unsigned AVAIL_W = CNT_W + 1;
  localparam int unsigned CONS_W  = $clog2(BANK_BYTES) + 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ext_state_e;

endpackage

// File: rtl/dfd_window_select.sv
// Byte rotator: selects a BANK-wide window starting at rd_ptr from {nxt, cur}.
module dfd_window_select
  import dfd_trace_pkg::*;
(
  input  logic [ACC_BYTES*8-1:0]  cur_i,
  input  logic [ACC_BYTES*8-1:0]  nxt_i,
  input  logic [PTR_W-1:0]        rd_ptr_i,
  input  logic [AVAIL_W-1:0]      avail_i,
  output logic [BANK_BYTES*8-1:0] win_data_o,
  output logic [BANK_BYTES-1:0]   win_be_o
);

  localparam int unsigned WIN_W = BANK_BYTES * 8;

  logic [2*ACC_BYTES*8-1:0] cat_c;
  logic [WIN_W-1:0]         rot_c;

  // Rotate the concatenated lines down to rd_ptr and blank bytes beyond avail.
  always_comb begin
    cat_c      = {nxt_i, cur_i};
    rot_c      = WIN_W'(cat_c >> {rd_ptr_i, 3'b000});
    win_data_o = '0;
    win_be_o   = '0;
    for (int k = 0; k < BANK_BYTES; k++) begin
      if (AVAIL_W'(k) < avail_i) begin
        win_be_o[k]          = 1'b1;
        win_data_o[k*8 +: 8] = rot_c[k*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dfd_packet_extractor.sv
// Unpacks accumulator-wide trace lines into an LSB-aligned BANK-wide byte window.
module dfd_packet_extractor
  import dfd_trace_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    line_valid_in,
  output logic                    line_ready_out,
  input  logic [ACC_BYTES*8-1:0]  line_data_in,
  input  logic [ACC_BYTES-1:0]    line_byte_be_in,
  input  logic                    flush_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic [CONS_W-1:0]       out_consume_bytes,
  output logic [BANK_BYTES*8-1:0] out_data,
  output logic [BANK_BYTES-1:0]   out_byte_be,
  output logic [PTR_W-1:0]        read_byte_boundary,
  output logic                    flush_done,
  output logic                    err_overconsume
);

  ext_state_e state_q, state_d;

  logic [ACC_BYTES*8-1:0]  cur_q, cur_d, nxt_q, nxt_d;
  logic [CNT_W-1:0]        cur_cnt_q, cur_cnt_d, nxt_cnt_q, nxt_cnt_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    err_q, err_d;
  logic                    out_valid_q, out_valid_d;
  logic [BANK_BYTES*8-1:0] out_data_q, out_data_d;
  logic [BANK_BYTES-1:0]   out_be_q, out_be_d;
  logic                    flush_done_q, flush_done_d;
  logic                    line_ready_q, line_ready_d;

  logic                    cur_vld_c, nxt_vld_c, cur_v_c, nxt_v_c;
  logic                    accept_c, consume_c;
  logic [CNT_W-1:0]        line_cnt_c, sum_c, rd_next_c;
  logic [CONS_W-1:0]       n_eff_c;
  logic [AVAIL_W-1:0]      avail_q_c, win_q_c, avail_d;
  logic [BANK_BYTES*8-1:0] win_data_c;
  logic [BANK_BYTES-1:0]   win_be_c;

  // Current-state view: entry valids, available bytes and the presented window size.
  always_comb begin
    cur_vld_c  = (state_q != ST_EMPTY);
    nxt_vld_c  = (state_q == ST_TWO);
    avail_q_c  = (cur_vld_c ? AVAIL_W'(cur_cnt_q) - AVAIL_W'(rd_ptr_q) : '0) +
                 (nxt_vld_c ? AVAIL_W'(nxt_cnt_q) : '0);
    win_q_c    = (avail_q_c >= AVAIL_W'(BANK_BYTES)) ? AVAIL_W'(BANK_BYTES) : avail_q_c;
    accept_c   = line_valid_in & line_ready_q;
    consume_c  = out_valid_q & out_ready;
    line_cnt_c = '0;
    for (int i = 0; i < ACC_BYTES; i++) begin
      line_cnt_c = line_cnt_c + CNT_W'(line_byte_be_in[i]);
    end
  end

  // Next state: consume/pop first, then place an accepted line, then resolve flush.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    nxt_d        = nxt_q;
    cur_cnt_d    = cur_cnt_q;
    nxt_cnt_d    = nxt_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    flush_pend_d = flush_pend_q | flush_in;
    err_d        = err_q;
    flush_done_d = 1'b0;
    cur_v_c      = cur_vld_c;
    nxt_v_c      = nxt_vld_c;
    n_eff_c      = out_consume_bytes;
    sum_c        = '0;
    rd_next_c    = CNT_W'(rd_ptr_q);

    if (consume_c) begin
      if (AVAIL_W'(out_consume_bytes) > win_q_c) begin
        err_d   = 1'b1;
        n_eff_c = CONS_W'(win_q_c);
      end
      sum_c     = CNT_W'(rd_ptr_q) + CNT_W'(n_eff_c);
      rd_next_c = sum_c;
      if (sum_c >= cur_cnt_q) begin
        cur_d     = nxt_q;
        cur_cnt_d = nxt_cnt_q;
        cur_v_c   = nxt_v_c;
        nxt_v_c   = 1'b0;
        rd_next_c = sum_c - cur_cnt_q;
      end
      // A short final line can be drained completely in the same pop.
      if (cur_v_c && (rd_next_c >= cur_cnt_d)) begin
        cur_v_c   = 1'b0;
        rd_next_c = '0;
      end
      rd_ptr_d = PTR_W'(rd_next_c);
    end

    if (accept_c) begin
      if (!cur_v_c) begin
        cur_d     = line_data_in;
        cur_cnt_d = line_cnt_c;
        cur_v_c   = 1'b1;
        rd_ptr_d  = '0;
      end else begin
        nxt_d     = line_data_in;
        nxt_cnt_d = line_cnt_c;
        nxt_v_c   = 1'b1;
      end
    end

    avail_d = (cur_v_c ? AVAIL_W'(cur_cnt_d) - AVAIL_W'(rd_ptr_d) : '0) +
              (nxt_v_c ? AVAIL_W'(nxt_cnt_d) : '0);

    if (flush_pend_d && (avail_d == '0)) begin
      flush_done_d = 1'b1;
      flush_pend_d = 1'b0;
      rd_ptr_d     = '0;
      cur_v_c      = 1'b0;
      nxt_v_c      = 1'b0;
    end

    state_d = nxt_v_c ? ST_TWO : (cur_v_c ? ST_ONE : ST_EMPTY);
  end

  dfd_window_select u_window_select (
    .cur_i      (cur_d),
    .nxt_i      (nxt_d),
    .rd_ptr_i   (rd_ptr_d),
    .avail_i    (avail_d),
    .win_data_o (win_data_c),
    .win_be_o   (win_be_c)
  );

  // Output values for the next cycle, derived from the post-update state.
  always_comb begin
    out_valid_d  = (avail_d >= AVAIL_W'(BANK_BYTES)) | (flush_pend_d & (avail_d != '0));
    out_data_d   = out_valid_d ? win_data_c : '0;
    out_be_d     = out_valid_d ? win_be_c : '0;
    line_ready_d = (state_d != ST_TWO);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Line entries, read pointer and flush/error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q        <= '0;
      nxt_q        <= '0;
      cur_cnt_q    <= '0;
      nxt_cnt_q    <= '0;
      rd_ptr_q     <= '0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      cur_cnt_q    <= cur_cnt_d;
      nxt_cnt_q    <= nxt_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      flush_pend_q <= flush_pend_d;
      err_q        <= err_d;
    end
  end

  // Registered outputs; ready comes out of reset high since both entries are free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_be_q     <= '0;
      flush_done_q <= 1'b0;
      line_ready_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_be_q     <= out_be_d;
      flush_done_q <= flush_done_d;
      line_ready_q <= line_ready_d;
    end
  end

  assign line_ready_out     = line_ready_q;
  assign out_valid          = out_valid_q;
  assign out_data           = out_data_q;
  assign out_byte_be        = out_be_q;
  assign read_byte_boundary = rd_ptr_q;
  assign flush_done         = flush_done_q;
  assign err_overconsume    = err_q;

endmodule

// File: tb/tb_dfd_packet_extractor.sv
// Self-checking bench: directed scenarios plus random traffic against a byte-queue model.
module tb_dfd_packet_extractor;
  import dfd_trace_pkg::*;

  localparam int ACC  = int'(ACC_BYTES);
  localparam int BANK = int'(BANK_BYTES);

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    line_valid_in = 1'b0;
  logic                    line_ready_out;
  logic [ACC*8-1:0]        line_data_in = '0;
  logic [ACC-1:0]          line_byte_be_in = '0;
  logic                    flush_in = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [CONS_W-1:0]       out_consume_bytes = '0;
  logic [BANK*8-1:0]       out_data;
  logic [BANK-1:0]         out_byte_be;
  logic [PTR_W-1:0]        read_byte_boundary;
  logic                    flush_done;
  logic                    err_overconsume;

  always #5 clk = ~clk;

  dfd_packet_extractor dut (
    .clk                (clk),
    .reset              (reset),
    .line_valid_in      (line_valid_in),
    .line_ready_out     (line_ready_out),
    .line_data_in       (line_data_in),
    .line_byte_be_in    (line_byte_be_in),
    .flush_in           (flush_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_consume_bytes  (out_consume_bytes),
    .out_data           (out_data),
    .out_byte_be        (out_byte_be),
    .read_byte_boundary (read_byte_boundary),
    .flush_done         (flush_done),
    .err_overconsume    (err_overconsume)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the unconsumed byte stream plus the remaining bytes of each held line.
  logic [7:0] m_bytes[$];
  int         m_rem[$];
  int         m_cnt[$];
  bit         m_pend, m_err, m_done;

  function automatic int m_total();
    return m_bytes.size();
  endfunction

  function automatic bit m_valid();
    return (m_total() >= BANK) || (m_pend && m_total() > 0);
  endfunction

  function automatic bit m_ready();
    return m_rem.size() < 2;
  endfunction

  function automatic int m_win();
    return (m_total() < BANK) ? m_total() : BANK;
  endfunction

  function automatic void model_reset();
    m_bytes.delete();
    m_rem.delete();
    m_cnt.delete();
    m_pend = 0;
    m_err  = 0;
    m_done = 0;
  endfunction

  function automatic void model_update(input bit acc, input logic [ACC*8-1:0] d, input int cnt,
                                       input bit cons, input int n_in, input bit fl);
    int n;
    n = n_in;
    if (cons) begin
      if (n > m_win()) begin
        m_err = 1;
        n = m_win();
      end
      for (int i = 0; i < n; i++) void'(m_bytes.pop_front());
      while (n > 0) begin
        int take;
        take = (n < m_rem[0]) ? n : m_rem[0];
        m_rem[0] -= take;
        n -= take;
        if (m_rem[0] == 0) begin
          void'(m_rem.pop_front());
          void'(m_cnt.pop_front());
        end
      end
    end
    if (acc) begin
      for (int i = 0; i < cnt; i++) m_bytes.push_back(d[i*8 +: 8]);
      m_rem.push_back(cnt);
      m_cnt.push_back(cnt);
    end
    m_pend = m_pend | fl;
    m_done = 0;
    if (m_pend && m_total() == 0) begin
      m_done = 1;
      m_pend = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [BANK*8-1:0] ed;
    logic [BANK-1:0]   eb;
    int                erd;
    ed = '0;
    eb = '0;
    if (m_valid()) begin
      for (int k = 0; k < m_win(); k++) begin
        ed[k*8 +: 8] = m_bytes[k];
        eb[k] = 1'b1;
      end
    end
    erd = (m_rem.size() > 0) ? (m_cnt[0] - m_rem[0]) : 0;
    chk("out_valid",  256'(out_valid),          256'(m_valid()));
    chk("out_data",   256'(out_data),           256'(ed));
    chk("out_be",     256'(out_byte_be),        256'(eb));
    chk("line_ready", 256'(line_ready_out),     256'(m_ready()));
    chk("rd_ptr",     256'(read_byte_boundary), 256'(erd));
    chk("flush_done", 256'(flush_done),         256'(m_done));
    chk("err_over",   256'(err_overconsume),    256'(m_err));
  endtask

  function automatic logic [ACC-1:0] cnt_to_be(input int cnt);
    logic [ACC-1:0] be;
    be = '0;
    for (int i = 0; i < cnt; i++) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [ACC*8-1:0] rnd_line();
    logic [ACC*8-1:0] d;
    for (int i = 0; i < ACC/4; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock of stimulus; the model advances with its own ready/valid view, then all outputs are checked.
  task automatic step(input bit lv, input logic [ACC*8-1:0] ld, input int cnt,
                      input bit fl, input bit ordy, input int n);
    bit pre_ready, pre_valid;
    line_valid_in     = lv;
    line_data_in      = ld;
    line_byte_be_in   = cnt_to_be(cnt);
    flush_in          = fl;
    out_ready         = ordy;
    out_consume_bytes = CONS_W'(n);
    pre_ready = m_ready();
    pre_valid = m_valid();
    @(posedge clk);
    model_update(lv && pre_ready, ld, cnt, ordy && pre_valid, n, fl);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    reset = 1'b1;
    line_valid_in = 1'b0;
    flush_in = 1'b0;
    out_ready = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_ready_const", 256'(line_ready_out), 256'(1));
    chk("rst_valid_const", 256'(out_valid), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [ACC*8-1:0] la, lb, lc, ld, zl;
  int guard;

  initial begin
    zl = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("init_ready_const", 256'(line_ready_out), 256'(1));
    reset = 1'b0;

    // Two full lines, consumed 32 at a time.
    la = rnd_line(); lb = rnd_line(); lc = rnd_line();
    step(1, la, 64, 0, 0, 0);
    step(1, lb, 64, 0, 0, 0);
    chk("s1_win0", 256'(out_data), 256'(la[255:0]));
    chk("s1_full_ready", 256'(line_ready_out), 256'(0));
    step(0, zl, 0, 0, 1, 32);
    chk("s1_win1", 256'(out_data), 256'(la[511:256]));
    step(0, zl, 0, 0, 1, 32);
    chk("s1_rd0", 256'(read_byte_boundary), 256'(0));
    chk("s1_ready", 256'(line_ready_out), 256'(1));
    chk("s1_winB", 256'(out_data), 256'(lb[255:0]));

    // Rollover window: consume 20 + 20 across the B/C boundary.
    step(1, lc, 64, 0, 0, 0);
    step(0, zl, 0, 0, 1, 20);
    step(0, zl, 0, 0, 1, 20);
    chk("s2_rd40", 256'(read_byte_boundary), 256'(40));
    chk("s2_roll", 256'(out_data), 256'({lc[63:0], lb[511:320]}));
    chk("s2_be", 256'(out_byte_be), 256'(32'hFFFF_FFFF));

    // Over-consume during flush drain: rd_ptr=50, 14 bytes left, consume 20.
    step(0, zl, 0, 0, 1, 24);
    step(0, zl, 0, 0, 1, 32);
    step(0, zl, 0, 0, 1, 18);
    chk("s5_rd50", 256'(read_byte_boundary), 256'(50));
    chk("s5_novalid", 256'(out_valid), 256'(0));
    step(0, zl, 0, 1, 0, 0);
    chk("s5_be14", 256'(out_byte_be), 256'(32'h3FFF));
    step(0, zl, 0, 0, 1, 20);
    chk("s5_err", 256'(err_overconsume), 256'(1));
    chk("s5_rdwrap", 256'(read_byte_boundary), 256'(0));
    chk("s5_done", 256'(flush_done), 256'(1));
    step(0, zl, 0, 0, 0, 0);
    chk("s5_err_sticky", 256'(err_overconsume), 256'(1));

    // Partial line flush, then flush with nothing buffered.
    async_reset();
    la = rnd_line();
    step(1, la, 10, 0, 0, 0);
    chk("s3_wait", 256'(out_valid), 256'(0));
    step(0, zl, 0, 1, 0, 0);
    chk("s3_valid", 256'(out_valid), 256'(1));
    chk("s3_be", 256'(out_byte_be), 256'(32'h3FF));
    step(0, zl, 0, 0, 1, 10);
    chk("s3_done", 256'(flush_done), 256'(1));
    step(0, zl, 0, 0, 0, 0);
    chk("s3_pulse", 256'(flush_done), 256'(0));
    step(0, zl, 0, 1, 0, 0);
    chk("s3_empty_flush", 256'(flush_done), 256'(1));

    // Backpressure: C held off while A,B occupy both entries.
    la = rnd_line(); lb = rnd_line(); lc = rnd_line();
    step(1, la, 64, 0, 0, 0);
    step(1, lb, 64, 0, 0, 0);
    step(1, lc, 64, 0, 0, 0);
    chk("s4_ready0", 256'(line_ready_out), 256'(0));
    step(1, lc, 64, 0, 1, 32);
    step(1, lc, 64, 0, 1, 32);
    step(1, lc, 64, 0, 0, 0);
    chk("s4_winB", 256'(out_data), 256'(lb[255:0]));
    chk("s4_ready_after", 256'(line_ready_out), 256'(0));
    repeat (4) step(0, zl, 0, 0, 1, 32);
    chk("s4_drained", 256'(out_valid), 256'(0));

    // Mid-operation reset with two lines held, then a fresh line.
    la = rnd_line(); lb = rnd_line(); ld = rnd_line();
    step(1, la, 64, 0, 0, 0);
    step(1, lb, 64, 0, 0, 0);
    async_reset();
    chk("s6_nodone", 256'(flush_done), 256'(0));
    step(1, ld, 64, 0, 0, 0);
    chk("s6_fresh", 256'(out_data), 256'(ld[255:0]));
    chk("s6_rd", 256'(read_byte_boundary), 256'(0));

    // Random traffic with full lines.
    async_reset();
    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, rnd_line(), 64, 0, $urandom % 2, $urandom_range(0, BANK));
    end
    // Final partial line, flush, and drain until done.
    step(1, rnd_line(), $urandom_range(1, ACC - 1), 0, 0, 0);
    while (m_rem.size() > 1 || !m_ready()) step(0, zl, 0, 0, 1, 32);
    step(1, rnd_line(), $urandom_range(1, ACC - 1), 1, 0, 0);
    guard = 0;
    while (!flush_done && guard < 200) begin
      step(0, zl, 0, 0, $urandom % 2, $urandom_range(0, BANK));
      guard++;
    end
    chk("rand_flush_done", 256'(flush_done), 256'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
